// File: rtl/wr_ptr_sync_ctrl.sv
// Write-side pointer/flag controller for an async FIFO: binary/Gray write pointer,
// read-pointer synchronizer, registered level/full/almost-full and sticky error flags.
module wr_ptr_sync_ctrl #(
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [PTR_WIDTH:0]   rptr_gray,
    input  logic [PTR_WIDTH:0]   afull_lvl,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr_gray,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 wfull,
    output logic                 wafull,
    output logic                 wovf,
    output logic                 gray_err
);

    localparam logic [PTR_WIDTH:0] ONE = 1;

    logic [PTR_WIDTH:0]                  wbin;
    logic [SYNC_STAGES-1:0][PTR_WIDTH:0] sync_q;
    logic [PTR_WIDTH:0]                  rsync;
    logic [PTR_WIDTH:0]                  rsync_prev;

    logic                 accept;
    logic                 ovf_set;
    logic [PTR_WIDTH:0]   wbin_next;
    logic [PTR_WIDTH:0]   wgray_next;
    logic [PTR_WIDTH:0]   rbin_sync;
    logic [PTR_WIDTH:0]   level_next;
    logic [PTR_WIDTH:0]   rsync_diff;
    logic                 full_next;
    logic                 afull_next;
    logic                 multi_bit;

    assign rsync = sync_q[SYNC_STAGES-1];
    assign waddr = wbin[PTR_WIDTH-1:0];

    always_comb begin
        accept     = winc & ~wfull;
        ovf_set    = winc & wfull;
        wbin_next  = wbin + {{PTR_WIDTH{1'b0}}, accept};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin_sync  = '0;
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
        for (int i = 0; i <= PTR_WIDTH; i++)
            rbin_sync[i] = ^(rsync >> i);
        level_next = wbin_next - rbin_sync;
        full_next  = (wgray_next == {~rsync[PTR_WIDTH:PTR_WIDTH-1], rsync[PTR_WIDTH-2:0]});
        afull_next = (level_next >= afull_lvl);
        // More than one bit set <=> clearing the lowest set bit leaves something
        rsync_diff = rsync ^ rsync_prev;
        multi_bit  = |(rsync_diff & (rsync_diff - ONE));
    end

    // Plain flop chain: nothing may sit between synchronizer stages
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_gray};
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin       <= '0;
            wptr_gray  <= '0;
            rsync_prev <= '0;
            wlevel     <= '0;
            wfull      <= 1'b0;
            wafull     <= 1'b0;
            wovf       <= 1'b0;
            gray_err   <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            wptr_gray  <= wgray_next;
            rsync_prev <= rsync;
            wlevel     <= level_next;
            wfull      <= full_next;
            wafull     <= afull_next;
            // Set beats clear so an error coinciding with err_clr is never lost
            wovf       <= ovf_set | (wovf & ~err_clr);
            gray_err   <= multi_bit | (gray_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_wr_ptr_sync_ctrl.sv
// Directed bench for wr_ptr_sync_ctrl at PTR_WIDTH=4, SYNC_STAGES=2.
module tb_wr_ptr_sync_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr_gray;
    logic [4:0] afull_lvl;
    logic       err_clr;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic [4:0] wlevel;
    logic       wfull;
    logic       wafull;
    logic       wovf;
    logic       gray_err;

    int checks   = 0;
    int failures = 0;

    wr_ptr_sync_ctrl #(.PTR_WIDTH(4), .SYNC_STAGES(2)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .rptr_gray (rptr_gray),
        .afull_lvl (afull_lvl),
        .err_clr   (err_clr),
        .waddr     (waddr),
        .wptr_gray (wptr_gray),
        .wlevel    (wlevel),
        .wfull     (wfull),
        .wafull    (wafull),
        .wovf      (wovf),
        .gray_err  (gray_err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        winc      = 1'b0;
        err_clr   = 1'b0;
        rptr_gray = '0;
        wrst_n    = 1'b0;
        tick();
        tick();
        wrst_n    = 1'b1;
    endtask

    initial begin
        logic [4:0] rb;
        int         exp_lvl;

        afull_lvl = 5'd17;
        do_reset();
        chk("rst_wlevel", wlevel, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_wptr", wptr_gray, 0);

        // Fill with no reads; afull_lvl above DEPTH keeps wafull low
        winc = 1'b1;
        repeat (15) tick();
        chk("fill15_wfull", wfull, 0);
        chk("fill15_wlevel", wlevel, 15);
        tick();
        chk("fill16_wfull", wfull, 1);
        chk("fill16_wlevel", wlevel, 16);
        chk("fill16_waddr", waddr, 0);
        chk("fill16_wptr", wptr_gray, 5'b11000);
        chk("fill16_wafull", wafull, 0);
        chk("fill16_wovf", wovf, 0);
        tick();
        chk("ovf_wovf", wovf, 1);
        chk("ovf_waddr", waddr, 0);
        chk("ovf_wptr", wptr_gray, 5'b11000);
        chk("ovf_wlevel", wlevel, 16);

        winc    = 1'b0;
        err_clr = 1'b1;
        tick();
        chk("clr_wovf", wovf, 0);
        winc = 1'b1;
        tick();
        chk("setwins_wovf", wovf, 1);
        winc    = 1'b0;
        err_clr = 1'b0;

        // Drain by one: visible only after the third edge
        rptr_gray = 5'b00001;
        tick();
        chk("drain1_wfull", wfull, 1);
        chk("drain1_wlevel", wlevel, 16);
        tick();
        chk("drain2_wfull", wfull, 1);
        tick();
        chk("drain3_wfull", wfull, 0);
        chk("drain3_wlevel", wlevel, 15);

        // Asynchronous reset mid-cycle with winc high
        winc      = 1'b1;
        rptr_gray = 5'b00101;
        #2;
        wrst_n = 1'b0;
        #1;
        chk("arst_wlevel", wlevel, 0);
        chk("arst_wptr", wptr_gray, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_wovf", wovf, 0);
        chk("arst_flags", {wfull, wafull, gray_err}, 0);
        tick();
        chk("arst_hold_wptr", wptr_gray, 0);
        chk("arst_hold_wlevel", wlevel, 0);
        winc      = 1'b0;
        rptr_gray = '0;
        wrst_n    = 1'b1;

        // Almost-full at 14
        afull_lvl = 5'd14;
        winc      = 1'b1;
        repeat (13) tick();
        chk("af13_wafull", wafull, 0);
        chk("af13_wlevel", wlevel, 13);
        tick();
        chk("af14_wafull", wafull, 1);
        chk("af14_wlevel", wlevel, 14);

        // Threshold 0 asserts on the first edge after reset
        afull_lvl = 5'd0;
        do_reset();
        chk("af0_pre", wafull, 0);
        tick();
        chk("af0_post", wafull, 1);
        afull_lvl = 5'd17;

        // Two-bit Gray jump
        do_reset();
        rptr_gray = 5'b00011;
        tick();
        chk("gerr_e1", gray_err, 0);
        tick();
        chk("gerr_e2", gray_err, 0);
        tick();
        chk("gerr_e3", gray_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("gerr_clr", gray_err, 0);
        rptr_gray = 5'b00010;
        repeat (3) tick();
        chk("gerr_legal", gray_err, 0);

        // Wrap: reader trails so that level settles at 4
        do_reset();
        for (int k = 1; k <= 35; k++) begin
            rb        = (k > 2) ? 5'(k - 2) : 5'd0;
            rptr_gray = rb ^ (rb >> 1);
            winc      = 1'b1;
            tick();
            exp_lvl = (k < 4) ? k : 4;
            chk($sformatf("wrap_lvl%0d", k), wlevel, exp_lvl);
            chk($sformatf("wrap_full%0d", k), wfull, 0);
        end
        winc = 1'b0;
        chk("wrap_waddr", waddr, 3);
        chk("wrap_wptr", wptr_gray, 5'b00010);
        chk("wrap_gerr", gray_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
